// File: rtl/led_matrix_pwm_driver.sv
// Scanning row driver for a red/green LED matrix with per-pixel PWM, inter-row
// blanking, and a double-buffered image that swaps only at frame boundaries.
module led_matrix_pwm_driver #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int BITS  = 2,
   parameter int DWELL = 4,
   parameter int BLANK = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ROWS*COLS*BITS-1:0] red_array,
   input  logic [ROWS*COLS*BITS-1:0] green_array,
   input  logic                      load,
   output logic [COLS-1:0]           red_driver,
   output logic [COLS-1:0]           green_driver,
   output logic [ROWS-1:0]           row_sink,
   output logic                      frame_end
);

   localparam int IMG_W = ROWS * COLS * BITS;
   localparam int ROW_W = $clog2(ROWS);
   localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int BC_W  = (BLANK > 1) ? $clog2(BLANK) : 1;

   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [BITS-1:0]  SLOT_LAST  = BITS'((2 ** BITS) - 2);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [BC_W-1:0]  BLANK_LAST = BC_W'(BLANK - 1);

   localparam logic [0:0] ST_BLANK  = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [0:0]       state;
   logic [ROW_W-1:0] row;
   logic [BITS-1:0]  slot;
   logic [DW_W-1:0]  dwell;
   logic [BC_W-1:0]  bcnt;

   logic             pend_flag;
   logic [IMG_W-1:0] pend_red;
   logic [IMG_W-1:0] pend_green;
   logic [IMG_W-1:0] disp_red;
   logic [IMG_W-1:0] disp_green;

   logic             last_cycle_of_row;

   // A pixel of level k is lit while the slot counter is below k, so level 0
   // never lights and the full-scale level lights for every slot.
   function automatic logic pixel_on(input logic [BITS-1:0] level,
                                     input logic [BITS-1:0] cur_slot);
      return level > cur_slot;
   endfunction

   assign last_cycle_of_row = (dwell == DWELL_LAST) && (slot == SLOT_LAST);
   assign frame_end = (state == ST_ACTIVE) && (row == ROW_LAST) && last_cycle_of_row;

   // Scan sequencer: BLANK for BLANK cycles, then ACTIVE for all PWM slots.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_BLANK;
         row   <= '0;
         slot  <= '0;
         dwell <= '0;
         bcnt  <= '0;
      end else begin
         case (state)
            ST_BLANK: begin
               if (bcnt == BLANK_LAST) begin
                  state <= ST_ACTIVE;
                  bcnt  <= '0;
                  slot  <= '0;
                  dwell <= '0;
               end else begin
                  bcnt <= bcnt + BC_W'(1);
               end
            end
            default: begin
               if (dwell == DWELL_LAST) begin
                  dwell <= '0;
                  if (slot == SLOT_LAST) begin
                     state <= ST_BLANK;
                     slot  <= '0;
                     row   <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                  end else begin
                     slot <= slot + BITS'(1);
                  end
               end else begin
                  dwell <= dwell + DW_W'(1);
               end
            end
         endcase
      end
   end

   // Double buffer: the display image only changes on the edge closing a
   // frame; a load on that same edge bypasses the pending buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_flag  <= 1'b0;
         pend_red   <= '0;
         pend_green <= '0;
         disp_red   <= '0;
         disp_green <= '0;
      end else if (frame_end) begin
         if (load) begin
            disp_red   <= red_array;
            disp_green <= green_array;
            pend_red   <= red_array;
            pend_green <= green_array;
            pend_flag  <= 1'b0;
         end else if (pend_flag) begin
            disp_red   <= pend_red;
            disp_green <= pend_green;
            pend_flag  <= 1'b0;
         end
      end else if (load) begin
         pend_red   <= red_array;
         pend_green <= green_array;
         pend_flag  <= 1'b1;
      end
   end

   always_comb begin
      red_driver   = '0;
      green_driver = '0;
      row_sink     = '1;
      if (state == ST_ACTIVE) begin
         row_sink[row] = 1'b0;
         for (int c = 0; c < COLS; c++) begin
            red_driver[c]   = pixel_on(disp_red[(int'(row) * COLS + c) * BITS +: BITS], slot);
            green_driver[c] = pixel_on(disp_green[(int'(row) * COLS + c) * BITS +: BITS], slot);
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_pwm_driver.sv
// Bench for led_matrix_pwm_driver: default and a small-parameter instance,
// compared every cycle against a timing-arithmetic model plus directed scenarios.
module tb_led_matrix_pwm_driver;

   localparam int R0 = 8, C0 = 8,  B0 = 2, D0 = 4, K0 = 1;
   localparam int W0 = R0 * C0 * B0, FP0 = 104;
   localparam int R1 = 4, C1 = 16, B1 = 3, D1 = 1, K1 = 2;
   localparam int W1 = R1 * C1 * B1, FP1 = 36;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [W0-1:0] red0 = '0, green0 = '0;
   logic          load0 = 1'b0;
   logic [C0-1:0] rd0, gd0;
   logic [R0-1:0] rs0;
   logic          fe0;

   logic [W1-1:0] red1 = '0, green1 = '0;
   logic          load1 = 1'b0;
   logic [C1-1:0] rd1, gd1;
   logic [R1-1:0] rs1;
   logic          fe1;

   led_matrix_pwm_driver dut0 (
      .clk(clk), .reset(reset), .red_array(red0), .green_array(green0), .load(load0),
      .red_driver(rd0), .green_driver(gd0), .row_sink(rs0), .frame_end(fe0));

   led_matrix_pwm_driver #(.ROWS(R1), .COLS(C1), .BITS(B1), .DWELL(D1), .BLANK(K1)) dut1 (
      .clk(clk), .reset(reset), .red_array(red1), .green_array(green1), .load(load1),
      .red_driver(rd1), .green_driver(gd1), .row_sink(rs1), .frame_end(fe1));

   int n_checks = 0;
   int n_pass   = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model state: cycle index since reset release and the two image buffers.
   int             t0 = 0, t1 = 0;
   logic [191:0]   md0 = '0, mg0 = '0, pd0 = '0, pg0 = '0;
   logic [191:0]   md1 = '0, mg1 = '0, pd1 = '0, pg1 = '0;
   logic           pf0 = 1'b0, pf1 = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         t0 <= 0; md0 <= '0; mg0 <= '0; pd0 <= '0; pg0 <= '0; pf0 <= 1'b0;
      end else begin
         if (t0 % FP0 == FP0 - 1) begin
            if (load0) begin
               md0 <= 192'(red0); mg0 <= 192'(green0);
               pd0 <= 192'(red0); pg0 <= 192'(green0); pf0 <= 1'b0;
            end else if (pf0) begin
               md0 <= pd0; mg0 <= pg0; pf0 <= 1'b0;
            end
         end else if (load0) begin
            pd0 <= 192'(red0); pg0 <= 192'(green0); pf0 <= 1'b1;
         end
         t0 <= t0 + 1;
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         t1 <= 0; md1 <= '0; mg1 <= '0; pd1 <= '0; pg1 <= '0; pf1 <= 1'b0;
      end else begin
         if (t1 % FP1 == FP1 - 1) begin
            if (load1) begin
               md1 <= 192'(red1); mg1 <= 192'(green1);
               pd1 <= 192'(red1); pg1 <= 192'(green1); pf1 <= 1'b0;
            end else if (pf1) begin
               md1 <= pd1; mg1 <= pg1; pf1 <= 1'b0;
            end
         end else if (load1) begin
            pd1 <= 192'(red1); pg1 <= 192'(green1); pf1 <= 1'b1;
         end
         t1 <= t1 + 1;
      end
   end

   // Expected outputs from the row/frame period arithmetic: which = 0 red,
   // 1 green, 2 row_sink, 3 frame_end.
   function automatic logic [31:0] model_out(input int which, input int rows, input int cols,
                                             input int bits, input int dwell, input int blank,
                                             input int t, input logic [191:0] dr,
                                             input logic [191:0] dg);
      int rp, fp, p, r, a, vr, vg;
      logic [31:0] rd, gd, sk;
      rp = blank + ((1 << bits) - 1) * dwell;
      fp = rows * rp;
      p  = t % rp;
      r  = (t / rp) % rows;
      rd = '0;
      gd = '0;
      sk = (32'd1 << rows) - 32'd1;
      if (p >= blank) begin
         a = p - blank;
         sk[r] = 1'b0;
         for (int c = 0; c < cols; c++) begin
            vr = 0;
            vg = 0;
            for (int b = 0; b < bits; b++) begin
               vr = vr | (int'(dr[(r * cols + c) * bits + b]) << b);
               vg = vg | (int'(dg[(r * cols + c) * bits + b]) << b);
            end
            rd[c] = (vr * dwell > a);
            gd[c] = (vg * dwell > a);
         end
      end
      case (which)
         0:       return rd;
         1:       return gd;
         2:       return sk;
         default: return 32'(t % fp == fp - 1);
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("red0",  32'(rd0), model_out(0, R0, C0, B0, D0, K0, t0, md0, mg0));
         check("green0", 32'(gd0), model_out(1, R0, C0, B0, D0, K0, t0, md0, mg0));
         check("sink0", 32'(rs0), model_out(2, R0, C0, B0, D0, K0, t0, md0, mg0));
         check("fend0", 32'(fe0), model_out(3, R0, C0, B0, D0, K0, t0, md0, mg0));
         check("red1",  32'(rd1), model_out(0, R1, C1, B1, D1, K1, t1, md1, mg1));
         check("green1", 32'(gd1), model_out(1, R1, C1, B1, D1, K1, t1, md1, mg1));
         check("sink1", 32'(rs1), model_out(2, R1, C1, B1, D1, K1, t1, md1, mg1));
         check("fend1", 32'(fe1), model_out(3, R1, C1, B1, D1, K1, t1, md1, mg1));
      end
   end

   task automatic wait_t0(input int m);
      int k = 0;
      while ((t0 % FP0) != m && k < 4 * FP0) begin @(negedge clk); k++; end
   endtask

   task automatic wait_t1(input int m);
      int k = 0;
      while ((t1 % FP1) != m && k < 4 * FP1) begin @(negedge clk); k++; end
   endtask

   typedef struct {
      int row; int col; int red; int green; int exp_r; int exp_g;
   } vec_t;
   vec_t tbl[6];

   int rc, gc, oc, fc;
   logic [7:0]  m8;
   logic [15:0] seq;
   logic [3:0]  prev;

   initial begin
      tbl[0] = '{2, 5, 1, 0, 4, 0};
      tbl[1] = '{2, 6, 2, 0, 8, 0};
      tbl[2] = '{2, 7, 0, 3, 0, 12};
      tbl[3] = '{0, 0, 3, 3, 12, 12};
      tbl[4] = '{7, 7, 2, 1, 8, 4};
      tbl[5] = '{4, 3, 0, 0, 0, 0};

      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      reset  = 1'b0;
      #1;
      check("rst_sink", 32'(rs0), 32'hFF);
      check("rst_red", 32'(rd0), 32'h0);
      check("rst_fend", 32'(fe0), 32'h0);
      @(negedge clk);
      check("row0_sink", 32'(rs0), 32'hFE);
      check("row0_red", 32'(rd0), 32'h0);

      // Deferred swap: load at cycle 50 stays invisible for the rest of frame 0.
      wait_t0(50);
      red0 = '1; green0 = '0; load0 = 1'b1;
      @(negedge clk);
      load0 = 1'b0;
      rc = 0; fc = 0;
      while (t0 < FP0) begin
         if (rd0 != 8'h00) rc++;
         if (fe0) fc++;
         @(negedge clk);
      end
      check("defer_dark", 32'(rc), 32'd0);
      check("first_fend", 32'(fc), 32'd1);
      rc = 0;
      repeat (FP0) begin
         if (rd0 == 8'hFF) rc++;
         @(negedge clk);
      end
      check("defer_full", 32'(rc), 32'd96);

      // Single-pixel PWM table.
      for (int i = 0; i < 6; i++) begin
         wait_t0(10);
         red0 = '0; green0 = '0;
         red0[(tbl[i].row * C0 + tbl[i].col) * B0 +: B0]   = 2'(tbl[i].red);
         green0[(tbl[i].row * C0 + tbl[i].col) * B0 +: B0] = 2'(tbl[i].green);
         load0 = 1'b1;
         @(negedge clk);
         load0 = 1'b0;
         wait_t0(0);
         rc = 0; gc = 0; oc = 0;
         m8 = 8'(1 << tbl[i].col);
         repeat (FP0) begin
            rc += int'(rd0[tbl[i].col]);
            gc += int'(gd0[tbl[i].col]);
            oc += $countones(rd0 & ~m8) + $countones(gd0 & ~m8);
            @(negedge clk);
         end
         check($sformatf("pwm_red_%0d", i), 32'(rc), 32'(tbl[i].exp_r));
         check($sformatf("pwm_grn_%0d", i), 32'(gc), 32'(tbl[i].exp_g));
         check($sformatf("pwm_other_%0d", i), 32'(oc), 32'd0);
      end

      // Load exactly in the frame_end cycle shows in the very next frame.
      wait_t0(FP0 - 1);
      red0 = {W0/2{2'b10}}; green0 = '0; load0 = 1'b1;
      @(negedge clk);
      load0 = 1'b0;
      rc = 0;
      repeat (FP0) begin
         if (rd0 == 8'hFF) rc++;
         @(negedge clk);
      end
      check("coinc_load", 32'(rc), 32'd64);

      // Two loads in one frame: only the second is ever displayed.
      wait_t0(20);
      red0 = {W0/2{2'b01}}; green0 = '0; load0 = 1'b1;
      @(negedge clk);
      load0 = 1'b0;
      wait_t0(60);
      red0 = '0; green0 = {W0/2{2'b01}}; load0 = 1'b1;
      @(negedge clk);
      load0 = 1'b0;
      wait_t0(0);
      rc = 0; gc = 0;
      repeat (FP0) begin
         if (rd0 != 8'h00) rc++;
         if (gd0 == 8'hFF) gc++;
         @(negedge clk);
      end
      check("last_wins_red", 32'(rc), 32'd0);
      check("last_wins_grn", 32'(gc), 32'd32);

      // Reset mid-row with a load pending.
      wait_t0(10);
      red0 = '1; green0 = '0; load0 = 1'b1;
      @(negedge clk);
      load0 = 1'b0;
      wait_t0(67);
      check("pre_rst_sink", 32'(rs0), 32'hDF);
      check("pre_rst_grn", 32'(gd0), 32'hFF);
      #2 reset = 1'b1;
      #1;
      check("async_sink0", 32'(rs0), 32'hFF);
      check("async_red0", 32'(rd0), 32'h0);
      check("async_grn0", 32'(gd0), 32'h0);
      check("async_fend0", 32'(fe0), 32'h0);
      check("async_sink1", 32'(rs1), 32'hF);
      @(negedge clk);
      reset = 1'b0;
      rc = 0; gc = 0;
      repeat (2 * FP0) begin
         if (rd0 != 8'h00) rc++;
         if (gd0 != 8'h00) gc++;
         @(negedge clk);
      end
      check("post_rst_red", 32'(rc), 32'd0);
      check("post_rst_grn", 32'(gc), 32'd0);

      // Parameter variant: intensity 5 at (1,4), row walk E,D,B,7.
      wait_t1(5);
      red1 = '0; green1 = '0;
      red1[(1 * C1 + 4) * B1 +: B1] = 3'd5;
      load1 = 1'b1;
      @(negedge clk);
      load1 = 1'b0;
      wait_t1(0);
      rc = 0; seq = '0; prev = 4'hF;
      repeat (FP1) begin
         rc += int'(rd1[4]);
         if (rs1 != 4'hF && prev == 4'hF) seq = {seq[11:0], rs1};
         prev = rs1;
         @(negedge clk);
      end
      check("var_pwm5", 32'(rc), 32'd5);
      check("var_rows", 32'(seq), 32'hEDB7);

      // Randomized loads on both instances against the model.
      for (int i = 0; i < 900; i++) begin
         load0 = ($urandom % 10) == 0;
         red0   = {$urandom, $urandom, $urandom, $urandom};
         green0 = {$urandom, $urandom, $urandom, $urandom};
         load1 = ($urandom % 7) == 0;
         red1   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         green1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
      end
      load0 = 1'b0;
      load1 = 1'b0;
      repeat (2 * FP0) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/led_matrix_pwm_driver.md
# led_matrix_pwm_driver

Parametrised, scanning row driver for a red/green LED matrix with per-pixel PWM intensity, inter-row blanking for ghost suppression, and a double-buffered frame image that swaps only at frame boundaries. It sits between the game/display logic, which presents a full intensity image plus a `load` strobe, and the matrix pins: column drivers and active-low row sinks. It replaces the fixed 8x8 on/off scanner.

## Interface
- `ROWS`, 8: matrix rows; ≥2.
- `COLS`, 8: matrix columns; ≥1.
- `BITS`, 2: intensity bits per pixel per colour; ≥1.
- `DWELL`, 4: clk cycles per PWM slot; ≥1.
- `BLANK`, 1: all-off clk cycles before each row's active phase; ≥1.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `red_array`  in  ROWS*COLS*BITS  red intensities; pixel (r,c) at `[(r*COLS+c)*BITS +: BITS]`.
- `green_array`  in  ROWS*COLS*BITS  green intensities, same packing.
- `load`  in  1  capture both arrays into the pending buffer on this edge.
- `red_driver`  out  COLS  red column drive; bit c = column c; 1 = on.
- `green_driver`  out  COLS  green column drive; same bit order.
- `row_sink`  out  ROWS  active-low one-hot row select; all 1 = no row.
- `frame_end`  out  1  high during the last clk cycle of each frame.

## Operation
- Two image buffers, red+green each: pending and display. Display drives the outputs; pending holds the latest load.
- `load` high at an edge: pending ← arrays and pend_flag ← 1. Several loads in one frame: the last one wins.
- Scan FSM states are BLANK and ACTIVE. Counters: `row` (0..ROWS-1), `slot` (0..2^BITS-2), `dwell` (0..DWELL-1), `bcnt` (0..BLANK-1).
- BLANK phase:
  - `row_sink` all 1s, both drivers 0.
  - Lasts BLANK cycles, then the FSM moves to ACTIVE with slot=0, dwell=0.
- ACTIVE phase:
  - `row_sink[row]`=0, all other sink bits 1.
  - `red_driver[c]` = (display_red(row,c) > slot); green likewise, using an unsigned BITS-wide compare.
  - Intensity 0 is always off. Intensity 2^BITS-1 is on for the whole active phase. Intensity k is on for the first k*DWELL active cycles.
  - `dwell` counts up to DWELL-1, wraps to 0, and increments `slot`. After the last cycle of the last slot, the FSM returns to BLANK and `row` increments, wrapping ROWS-1 → 0.
- `frame_end` = ACTIVE ∧ row=ROWS-1 ∧ slot=2^BITS-2 ∧ dwell=DWELL-1.
- Buffer swap on the edge that ends a `frame_end` cycle:
  - If pend_flag: display ← pending, pend_flag ← 0.
  - If `load` is also high on that same edge: display ← arrays directly, pending ← arrays, pend_flag ← 0.
  - The display buffer never changes at any other time. There is no tearing.
- Reset, asynchronous at any time including mid-row:
  - FSM=BLANK, row/slot/dwell/bcnt=0.
  - Both buffers all 0; pend_flag=0.
  - Any pending load is discarded.

## Timing
- Reset values: `row_sink`=all 1s, `red_driver`=`green_driver`=0, `frame_end`=0.
- Outputs are combinational decodes of registered state and display buffers: zero added latency and no output registers.
- Row period = BLANK + (2^BITS-1)*DWELL cycles. Frame period = ROWS × row period. Defaults: 13 and 104 cycles.
- After reset deasserts: BLANK cycles of all-off, then row 0 active.
- Load-to-display latency: from the load edge to the next `frame_end` edge, which is at most one frame period.
- `load` needs no handshake; it is accepted on every cycle. Array inputs must be stable at the edge where `load` is sampled.

## Test plan
- **Reset:** assert reset mid-simulation, then release → `row_sink`=8'hFF, drivers 0, `frame_end` 0 for 1 cycle; then `row_sink`=8'hFE with drivers 0 (display cleared). `frame_end` pulses every 104 cycles, first at cycle 104.
- **Deferred swap:** load all red=3, green=0 at cycle 50 → display stays 0 through cycle 103. The next frame shows `red_driver`=8'hFF for 12 cycles per row, and `row_sink` walks FE,FD,…,7F with one all-FF cycle between rows.
- **PWM:** pixel (2,5) red=1, (2,6) red=2, (2,7) green=3 → in row 2's active phase, `red_driver` bit5 is high for active cycles 0–3, bit6 for 0–7, and `green_driver` bit7 for 0–11. All other bits are 0.
- **Load coincidence:** `load` high exactly in a `frame_end` cycle → data appears in the immediately following frame. Two loads in one frame (A then B) → only B is ever displayed.
- **Reset mid-operation:** reset asserted during row 5 active, with a load pending → outputs go to FF/0/0 immediately with no clock edge. After release the display is 0 and the pending image is never shown.
- **Parameter variant:** ROWS=4, COLS=16, BITS=3, DWELL=1, BLANK=2 → row period 9 and frame 36. Intensity 5 is on for exactly 5 cycles per row; `row_sink` cycles E,D,B,7.
